toggle_cover_collector: RTL and testbench

- Parametrised successor to the fixed 5-bit toggle cover point.
- Watches a WIDTH-bit signal vector and detects rising and falling toggles per bit.
- Keeps sticky hit bitmaps and drains each newly covered point, once, through a valid/ready report port as a global cover index.
- Fully synthesizable, with no simulator call-out, so the same coverage is usable in formal, FPGA and simulation flows.

---
 rtl/toggle_cover_collector_if.sv | 8 +
 rtl/toggle_cover_collector.sv | 76 +++++++
 tb/tb_toggle_cover_collector.sv | 134 +++++++++++++
 3 files changed

// File: rtl/toggle_cover_collector_if.sv
// toggle_cover_collector_if: valid/ready report channel carrying a global cover index
interface toggle_cover_collector_if #(parameter int IW = 16);
  logic out_valid;
  logic out_ready;
  logic [IW-1:0] out_index;
  modport master(output out_valid, output out_index, input out_ready);
  modport slave(input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/toggle_cover_collector.sv
// toggle_cover_collector: per-bit rise/fall toggle coverage with sticky hits and serialised index reports
module toggle_cover_collector #(
  parameter int WIDTH = 5,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 38253,
  parameter int TRACK_FALL = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic [WIDTH-1:0] sig,
  toggle_cover_collector_if.master rpt,
  output logic [$clog2(2*WIDTH+1)-1:0] covered_count,
  output logic all_covered
);
  localparam int N = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam int LW = $clog2(N);
  localparam int IW = $clog2(COVER_TOTAL);
  localparam int EN_PTS = (TRACK_FALL != 0) ? N : WIDTH;
  if (WIDTH < 1 || WIDTH > 256 || COVER_INDEX + N > COVER_TOTAL) begin : g_bad_params
    $error("toggle_cover_collector: illegal WIDTH/COVER_INDEX/COVER_TOTAL");
  end
  logic [WIDTH-1:0] prev;
  logic primed;
  logic [N-1:0] hit, pend, ev, newhit, drain;
  logic [CW-1:0] cnt, pop;
  logic [LW-1:0] low;
  logic allc;
  always_comb begin
    ev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ev[2*i]   = primed & en & ~prev[i] & sig[i];
      ev[2*i+1] = primed & en & prev[i] & ~sig[i] & (TRACK_FALL != 0);
    end
    newhit = ev & ~hit;
    pop = '0;
    for (int k = 0; k < N; k++) pop = pop + CW'(newhit[k]);
    low = '0;
    for (int k = N - 1; k >= 0; k--) if (pend[k]) low = LW'(k);
    drain = '0;
    drain[low] = (|pend) & rpt.out_ready;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      prev <= '0;
      primed <= 1'b0;
      hit <= '0;
      pend <= '0;
      cnt <= '0;
      allc <= 1'b0;
    end else begin
      if (en) begin
        prev <= sig;
        primed <= 1'b1;
      end
      // clear wins over both new hits and a same-cycle handshake
      if (clear) begin
        hit <= '0;
        pend <= '0;
        cnt <= '0;
        allc <= 1'b0;
      end else begin
        hit <= hit | newhit;
        pend <= (pend & ~drain) | newhit;
        cnt <= cnt + pop;
        allc <= (cnt + pop) == CW'(EN_PTS);
      end
    end
  end
  assign rpt.out_valid = |pend;
  assign rpt.out_index = IW'(COVER_INDEX) + IW'(low);
  assign covered_count = cnt;
  assign all_covered = allc;
endmodule

// File: tb/tb_toggle_cover_collector.sv
// tb_toggle_cover_collector: directed checks of toggle detection, report ordering, clear and reset
module tb_toggle_cover_collector;
  logic clock = 1'b0;
  logic reset, en, clear, b_en, b_clear;
  logic [4:0] sig;
  logic [2:0] b_sig;
  logic [3:0] cc;
  logic [2:0] b_cc;
  logic allc, b_allc;
  int tests = 0, errors = 0;
  toggle_cover_collector_if #(.IW(16)) a_if ();
  toggle_cover_collector_if #(.IW(16)) b_if ();
  toggle_cover_collector #(.WIDTH(5), .COVER_INDEX(100), .COVER_TOTAL(38253), .TRACK_FALL(1)) dut_a (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .sig(sig), .rpt(a_if.master),
    .covered_count(cc), .all_covered(allc));
  toggle_cover_collector #(.WIDTH(3), .COVER_INDEX(100), .COVER_TOTAL(38253), .TRACK_FALL(0)) dut_b (
    .clock(clock), .reset(reset), .en(b_en), .clear(b_clear), .sig(b_sig), .rpt(b_if.master),
    .covered_count(b_cc), .all_covered(b_allc));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic rst_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b0; en = 1'b0; clear = 1'b0; sig = '0; a_if.out_ready = 1'b0;
    b_en = 1'b0; b_clear = 1'b0; b_sig = '0; b_if.out_ready = 1'b0;
    #1;
    rst_pulse();
    chk("rst_valid", 32'(a_if.out_valid), 0);
    chk("rst_index", 32'(a_if.out_index), 100);
    chk("rst_count", 32'(cc), 0);
    chk("rst_all", 32'(allc), 0);
    en = 1'b1; sig = 5'b00000; tick();
    sig = 5'b00001; tick();
    chk("t1_valid", 32'(a_if.out_valid), 1);
    chk("t1_index", 32'(a_if.out_index), 100);
    a_if.out_ready = 1'b1; tick(); a_if.out_ready = 1'b0;
    chk("t1_count", 32'(cc), 1);
    chk("t1_drained", 32'(a_if.out_valid), 0);
    rst_pulse();
    sig = 5'b11111; tick();
    chk("t2_first_count", 32'(cc), 0);
    chk("t2_first_valid", 32'(a_if.out_valid), 0);
    sig = 5'b00000; tick();
    chk("t2_count", 32'(cc), 5);
    a_if.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_valid", 32'(a_if.out_valid), 1);
      chk("t2_index", 32'(a_if.out_index), 32'(101 + 2 * k));
      tick();
    end
    a_if.out_ready = 1'b0;
    chk("t2_empty", 32'(a_if.out_valid), 0);
    rst_pulse();
    sig = 5'b00000; tick();
    sig = 5'b11111; tick();
    chk("t3_half_all", 32'(allc), 0);
    sig = 5'b00000; tick();
    chk("t3_count", 32'(cc), 10);
    chk("t3_all", 32'(allc), 1);
    a_if.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t3_valid", 32'(a_if.out_valid), 1);
      chk("t3_index", 32'(a_if.out_index), 32'(100 + k));
      tick();
    end
    a_if.out_ready = 1'b0;
    chk("t3_empty", 32'(a_if.out_valid), 0);
    chk("t3_count_kept", 32'(cc), 10);
    rst_pulse();
    sig = 5'b00000; tick();
    sig = 5'b00100; tick();
    chk("t4_count1", 32'(cc), 1);
    chk("t4_index", 32'(a_if.out_index), 104);
    a_if.out_ready = 1'b1; tick(); a_if.out_ready = 1'b0;
    sig = 5'b00000; tick();
    chk("t4_count2", 32'(cc), 2);
    chk("t4_fall_index", 32'(a_if.out_index), 105);
    a_if.out_ready = 1'b1; tick(); a_if.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sig = 5'b00100; tick();
      chk("t4_rep_rise", 32'(a_if.out_valid), 0);
      sig = 5'b00000; tick();
      chk("t4_rep_fall", 32'(a_if.out_valid), 0);
    end
    chk("t4_count_final", 32'(cc), 2);
    b_en = 1'b1; b_sig = 3'b000; tick();
    b_sig = 3'b111; tick();
    b_sig = 3'b000; tick();
    chk("t5_count", 32'(b_cc), 3);
    chk("t5_all", 32'(b_allc), 1);
    b_if.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_valid", 32'(b_if.out_valid), 1);
      chk("t5_index", 32'(b_if.out_index), 32'(100 + 2 * k));
      tick();
    end
    b_if.out_ready = 1'b0;
    chk("t5_empty", 32'(b_if.out_valid), 0);
    chk("t5_count_kept", 32'(b_cc), 3);
    rst_pulse();
    sig = 5'b00000; tick();
    sig = 5'b00001; tick();
    chk("t6_pre_valid", 32'(a_if.out_valid), 1);
    sig = 5'b00011; a_if.out_ready = 1'b1; clear = 1'b1; tick();
    clear = 1'b0; a_if.out_ready = 1'b0;
    chk("t6_clr_valid", 32'(a_if.out_valid), 0);
    chk("t6_clr_count", 32'(cc), 0);
    chk("t6_clr_all", 32'(allc), 0);
    sig = 5'b00000; tick();
    chk("t6_prev_kept_count", 32'(cc), 2);
    chk("t6_prev_kept_index", 32'(a_if.out_index), 101);
    a_if.out_ready = 1'b1; tick(); a_if.out_ready = 1'b0;
    chk("t6_next_index", 32'(a_if.out_index), 103);
    rst_pulse();
    chk("t6_rst_valid", 32'(a_if.out_valid), 0);
    chk("t6_rst_index", 32'(a_if.out_index), 100);
    chk("t6_rst_count", 32'(cc), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
